// File: rtl/pll_rst_seq_pkg.sv
// Shared state encoding and sizing helper for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int STATE_W = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Two-flop synchronizer for a single slow status bit crossing into clk.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL power-up / lock supervision: holds the PLL in reset, waits for and
// debounces lock, releases the downstream reset, retries and parks on failure.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 240,
  parameter int unsigned LOCK_TIMEOUT  = 24000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_extlock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] unlock_cnt
);

  localparam int unsigned TMAX    = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int          TIMER_W = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  localparam logic [TIMER_W-1:0] RST_END    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_END     = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_END = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]         RETRY_LIM  = 4'(MAX_RETRY);

  logic               w_lock_s;
  state_t             r_state;
  state_t             w_next_state;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_next;
  logic [3:0]         r_retry;
  logic [3:0]         w_retry_next;
  logic [7:0]         r_unlock;
  logic [7:0]         w_unlock_next;
  logic               r_pll_reset, w_pll_reset;
  logic               r_sys_rst_n, w_sys_rst_n;
  logic               r_locked, w_locked;
  logic               r_fail, w_fail;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_extlock),
    .o_q   (w_lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HOLD;
      r_timer     <= '0;
      r_retry     <= '0;
      r_unlock    <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_timer     <= w_timer_next;
      r_retry     <= w_retry_next;
      r_unlock    <= w_unlock_next;
      r_pll_reset <= w_pll_reset;
      r_sys_rst_n <= w_sys_rst_n;
      r_locked    <= w_locked;
      r_fail      <= w_fail;
    end
  end

  // restart overrides everything; lock beats a coincident timeout in WAIT.
  always_comb begin
    w_next_state  = r_state;
    w_retry_next  = r_retry;
    w_unlock_next = r_unlock;
    if (restart) begin
      w_next_state = S_HOLD;
      w_retry_next = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_timer == RST_END) w_next_state = S_WAIT;
        end
        S_WAIT: begin
          if (w_lock_s) begin
            w_next_state = S_STABLE;
          end else if (r_timer == TO_END) begin
            w_retry_next = r_retry + 4'd1;
            w_next_state = (w_retry_next == RETRY_LIM) ? S_FAIL : S_HOLD;
          end
        end
        S_STABLE: begin
          if (!w_lock_s) begin
            w_next_state = S_WAIT;
          end else if (r_timer == STABLE_END) begin
            w_next_state = S_RUN;
            w_retry_next = '0;
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            w_next_state = S_HOLD;
            if (r_unlock != 8'hFF) w_unlock_next = r_unlock + 8'd1;
          end
        end
        S_FAIL:  w_next_state = S_FAIL;
        default: w_next_state = S_HOLD;
      endcase
    end
    w_timer_next = (restart || (w_next_state != r_state)) ? '0 : r_timer + 1'b1;
  end

  // Outputs are decoded from the next state so they register on the entry edge.
  always_comb begin
    w_pll_reset = 1'b0;
    w_sys_rst_n = 1'b0;
    w_locked    = 1'b0;
    w_fail      = 1'b0;
    case (w_next_state)
      S_HOLD:   w_pll_reset = 1'b1;
      S_WAIT:   w_pll_reset = 1'b0;
      S_STABLE: w_pll_reset = 1'b0;
      S_RUN: begin
        w_sys_rst_n = 1'b1;
        w_locked    = 1'b1;
      end
      S_FAIL: begin
        w_pll_reset = 1'b1;
        w_fail      = 1'b1;
      end
      default:  w_pll_reset = 1'b1;
    endcase
  end

  assign pll_reset  = r_pll_reset;
  assign sys_rst_n  = r_sys_rst_n;
  assign locked     = r_locked;
  assign fail       = r_fail;
  assign state      = r_state;
  assign retry_cnt  = r_retry;
  assign unlock_cnt = r_unlock;

endmodule
